// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/status inputs and datapath control outputs of the multicycle controller
interface multicycle_ctrl_if;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        Zero;
    logic        Mem_ready;
    logic        PC_we;
    logic        IR_we;
    logic        Extend_sel;
    logic        ALUSrc;
    logic [2:0]  ALU_op;
    logic        RegDst;
    logic        Reg_we;
    logic        MemtoReg;
    logic        Mem_re;
    logic        Mem_we;
    logic        Branch_taken;
    logic        Illegal;
    logic [2:0]  State;
    logic [15:0] Retired;
    modport master (
        output Op, Funct, Zero, Mem_ready,
        input  PC_we, IR_we, Extend_sel, ALUSrc, ALU_op, RegDst, Reg_we, MemtoReg,
               Mem_re, Mem_we, Branch_taken, Illegal, State, Retired
    );
    modport slave (
        input  Op, Funct, Zero, Mem_ready,
        output PC_we, IR_we, Extend_sel, ALUSrc, ALU_op, RegDst, Reg_we, MemtoReg,
               Mem_re, Mem_we, Branch_taken, Illegal, State, Retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EX/MEM/WB control FSM for a small MIPS subset with retired-instruction counter
module multicycle_ctrl (
    input logic            clk,
    input logic            rst,
    multicycle_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_ERR = 3'd5} state_t;
    state_t      state, state_nx;
    logic [5:0]  op_q, funct_q;
    logic [15:0] retired_q;
    logic        is_r, is_lw, is_sw, is_beq, sext, retire;
    logic [2:0]  alu_fn;
    logic        pc_we, ir_we, ext_sel, alu_src, reg_dst, reg_we, mem_to_reg, mem_re, mem_we, br_taken;
    logic [2:0]  alu_op;

    function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'b000000) ? (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
                                 : (op inside {6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001111,
                                               6'b100011, 6'b101011, 6'b000100});
    endfunction

    assign is_r   = op_q == 6'b000000;
    assign is_lw  = op_q == 6'b100011;
    assign is_sw  = op_q == 6'b101011;
    assign is_beq = op_q == 6'b000100;
    assign sext   = op_q inside {6'b001000, 6'b001001, 6'b100011, 6'b101011, 6'b000100};

    always_comb begin
        alu_fn = 3'b000;
        if (is_r)
            case (funct_q)
                6'b100010: alu_fn = 3'b001;
                6'b100100: alu_fn = 3'b010;
                6'b100101: alu_fn = 3'b011;
                6'b101010: alu_fn = 3'b100;
                default:   alu_fn = 3'b000;
            endcase
        else
            case (op_q)
                6'b001100: alu_fn = 3'b010;
                6'b001101: alu_fn = 3'b011;
                6'b001111: alu_fn = 3'b101;
                6'b000100: alu_fn = 3'b001;
                default:   alu_fn = 3'b000;
            endcase
    end

    // Decode uses only the latched opcode; live Op/Funct steer just the ID->EX/ERR choice.
    always_comb begin
        state_nx   = S_IF;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        ext_sel    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 3'b000;
        reg_dst    = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        br_taken   = 1'b0;
        retire     = 1'b0;
        if (state inside {S_EX, S_MEM, S_WB}) begin
            ext_sel = sext;
            alu_src = !is_r && !is_beq;
            alu_op  = alu_fn;
            reg_dst = is_r;
        end
        case (state)
            S_IF: begin
                pc_we    = !rst;
                ir_we    = !rst;
                state_nx = S_ID;
            end
            S_ID:  state_nx = legal(bus.Op, bus.Funct) ? S_EX : S_ERR;
            S_EX: begin
                br_taken = is_beq && bus.Zero;
                pc_we    = is_beq && bus.Zero;
                retire   = is_beq;
                state_nx = is_beq ? S_IF : (is_lw || is_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_re   = is_lw;
                mem_we   = is_sw;
                retire   = bus.Mem_ready && is_sw;
                state_nx = !bus.Mem_ready ? S_MEM : is_lw ? S_WB : S_IF;
            end
            S_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = is_lw;
                retire     = 1'b1;
            end
            S_ERR:   state_nx = S_ERR;
            default: state_nx = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IF;
            op_q      <= 6'd0;
            funct_q   <= 6'd0;
            retired_q <= 16'd0;
        end else begin
            state <= state_nx;
            if (state == S_ID) begin
                op_q    <= bus.Op;
                funct_q <= bus.Funct;
            end
            if (retire)
                retired_q <= retired_q + 16'd1;
        end
    end

    assign bus.PC_we        = pc_we;
    assign bus.IR_we        = ir_we;
    assign bus.Extend_sel   = ext_sel;
    assign bus.ALUSrc       = alu_src;
    assign bus.ALU_op       = alu_op;
    assign bus.RegDst       = reg_dst;
    assign bus.Reg_we       = reg_we;
    assign bus.MemtoReg     = mem_to_reg;
    assign bus.Mem_re       = mem_re;
    assign bus.Mem_we       = mem_we;
    assign bus.Branch_taken = br_taken;
    assign bus.Illegal      = state == S_ERR;
    assign bus.State        = state;
    assign bus.Retired      = retired_q;
endmodule
